// File: rtl/boundary_frame_sequencer.sv
// boundary_frame_sequencer: frame-phase control of the coordinate FIFO pair and read-side framing for the box reducers
module boundary_frame_sequencer #(
  parameter int CNT_W       = 16,
  parameter int DEPTH       = 4096,
  parameter int SKIP_FRAMES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lcd_vs,
  input  logic             enable,
  input  logic             pix_valid,
  input  logic             fg_pix,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             fifo_srst,
  output logic             fifo_wr_en,
  output logic             fifo_rd_en,
  output logic             rd_data_valid,
  output logic             rd_data_first,
  output logic             rd_data_last,
  output logic             publish,
  output logic             box_valid,
  output logic             overflow,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] entry_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_REDUCE, S_PUBLISH, S_HOLD} state_t;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] SKIP_C  = CNT_W'(SKIP_FRAMES);
  state_t           r_state, w_next;
  logic             r_vs_d, r_srst, r_overflow, r_box_valid;
  logic             r_rd_valid, r_rd_first, r_rd_last, r_first_pend;
  logic [CNT_W-1:0] r_entry_cnt, r_rd_rem, r_hold_cnt, w_cnt_next;
  logic             w_vs_fall, w_fg, w_wr_en, w_rd_en, w_drop, w_cap_end, w_abort;
  assign w_vs_fall  = r_vs_d & ~lcd_vs;
  assign w_fg       = pix_valid & fg_pix;
  assign w_wr_en    = (r_state == S_CAPTURE) & ~r_srst & w_fg & ~fifo_full & (r_entry_cnt < DEPTH_C);
  assign w_drop     = (r_state == S_CAPTURE) & ~r_srst & w_fg & ~w_wr_en;
  assign w_rd_en    = (r_state == S_REDUCE) & (r_rd_rem != '0) & ~fifo_empty & ~w_vs_fall;
  assign w_cap_end  = (r_state == S_CAPTURE) & w_vs_fall;
  assign w_abort    = (r_state == S_REDUCE) & w_vs_fall & (r_rd_rem != '0);
  assign w_cnt_next = r_srst ? '0 : r_entry_cnt + CNT_W'(w_wr_en);
  // next frame phase; a reduce ends when the countdown is exhausted or the next boundary arrives
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = (w_vs_fall & enable) ? S_CAPTURE : S_IDLE;
      S_CAPTURE: w_next = w_vs_fall ? S_REDUCE : S_CAPTURE;
      S_REDUCE:  w_next = (w_vs_fall | (r_rd_rem == '0)) ? S_PUBLISH : S_REDUCE;
      S_PUBLISH: w_next = S_HOLD;
      S_HOLD:    w_next = (w_vs_fall & (r_hold_cnt == SKIP_C)) ? (enable ? S_CAPTURE : S_IDLE) : S_HOLD;
      default:   w_next = S_IDLE;
    endcase
  end
  // phase register, boundary detector and the clear strobe for the first capture cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_vs_d  <= 1'b0;
      r_srst  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_vs_d  <= lcd_vs;
      r_srst  <= (w_next == S_CAPTURE) & (r_state != S_CAPTURE);
    end
  end
  // capture entry count and sticky overflow from dropped pixels or an aborted reduce
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entry_cnt <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (r_state == S_CAPTURE) r_entry_cnt <= w_cnt_next;
      if (r_srst) r_overflow <= 1'b0;
      else if (w_drop | w_abort) r_overflow <= 1'b1;
    end
  end
  // read countdown and read framing, delayed one cycle to line up with FIFO dout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_rem     <= '0;
      r_first_pend <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_first   <= 1'b0;
      r_rd_last    <= 1'b0;
    end else begin
      if (w_cap_end) r_rd_rem <= w_cnt_next;
      else if (w_rd_en) r_rd_rem <= r_rd_rem - CNT_W'(1);
      r_first_pend <= w_cap_end | (r_first_pend & ~w_rd_en);
      r_rd_valid   <= w_rd_en;
      r_rd_first   <= w_rd_en & r_first_pend;
      r_rd_last    <= w_rd_en & (r_rd_rem == CNT_W'(1));
    end
  end
  // publish latches box validity and restarts the count of hold frames
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_box_valid <= 1'b0;
      r_hold_cnt  <= '0;
    end else if (r_state == S_PUBLISH) begin
      r_box_valid <= (r_entry_cnt != '0) & ~r_overflow;
      r_hold_cnt  <= '0;
    end else if ((r_state == S_HOLD) & w_vs_fall) begin
      r_hold_cnt  <= r_hold_cnt + CNT_W'(1);
    end
  end
  assign fifo_srst     = r_srst;
  assign fifo_wr_en    = w_wr_en;
  assign fifo_rd_en    = w_rd_en;
  assign rd_data_valid = r_rd_valid;
  assign rd_data_first = r_rd_first;
  assign rd_data_last  = r_rd_last;
  assign publish       = r_state == S_PUBLISH;
  assign box_valid     = r_box_valid;
  assign overflow      = r_overflow;
  assign entry_cnt     = r_entry_cnt;
  assign phase         = (r_state == S_HOLD) ? 2'd3 : r_state[1:0];
endmodule

// File: tb/tb_boundary_frame_sequencer.sv
// tb_boundary_frame_sequencer: directed and randomized frames checked every cycle against a frame-rule model
module tb_boundary_frame_sequencer;
  localparam int CNT_W = 16;
  localparam int DEPTH = 8;
  localparam int SKIP  = 1;
  logic clk = 0, rst = 1, lcd_vs = 0, enable = 0, pix_valid = 0, fg_pix = 0, stall = 0;
  logic fifo_full, fifo_empty, fifo_srst, fifo_wr_en, fifo_rd_en;
  logic rd_data_valid, rd_data_first, rd_data_last, publish, box_valid, overflow;
  logic [1:0] phase;
  logic [CNT_W-1:0] entry_cnt;
  int occ = 0, cap = 16;
  int n_vec = 0, n_err = 0, cyc = 0;
  int m_mode = 0, m_age = 0, m_wr = 0, m_rem = 0, m_reads = 0, m_hold = 0;
  bit m_vs_d = 0, m_ovf = 0, m_box = 0, m_pv = 0, m_pf = 0, m_pl = 0;
  int t_wr = 0, t_rd = 0, t_first = 0, t_last = 0, t_pub = 0;
  int c_pub = 0, c_last = 0, c_red = 0, p_entry = 0, prev_phase = 0;
  bit p_ovf = 0;
  int b_wr = 0, b_rd = 0, b_first = 0, b_last = 0, b_pub = 0;

  boundary_frame_sequencer #(.CNT_W(CNT_W), .DEPTH(DEPTH), .SKIP_FRAMES(SKIP)) dut (
    .clk(clk), .rst(rst), .lcd_vs(lcd_vs), .enable(enable), .pix_valid(pix_valid), .fg_pix(fg_pix),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_srst(fifo_srst), .fifo_wr_en(fifo_wr_en),
    .fifo_rd_en(fifo_rd_en), .rd_data_valid(rd_data_valid), .rd_data_first(rd_data_first),
    .rd_data_last(rd_data_last), .publish(publish), .box_valid(box_valid), .overflow(overflow),
    .phase(phase), .entry_cnt(entry_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) occ <= fifo_srst ? 0 : occ + int'(fifo_wr_en) - int'(fifo_rd_en);
  assign fifo_full  = occ >= cap;
  assign fifo_empty = (occ == 0) || stall;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    bit vf, fg, e_srst, e_wr, e_rd;
    cyc++;
    if (rst) begin
      m_mode = 0; m_age = 0; m_wr = 0; m_rem = 0; m_reads = 0; m_hold = 0;
      m_vs_d = 0; m_ovf = 0; m_box = 0; m_pv = 0; m_pf = 0; m_pl = 0;
    end
    vf     = m_vs_d && !lcd_vs;
    fg     = pix_valid && fg_pix;
    e_srst = m_mode == 1 && m_age == 0;
    e_wr   = m_mode == 1 && !e_srst && fg && !fifo_full && m_wr < DEPTH;
    e_rd   = m_mode == 2 && m_rem > 0 && !fifo_empty && !vf;
    chk1("fifo_srst", fifo_srst, e_srst);
    chk1("fifo_wr_en", fifo_wr_en, e_wr);
    chk1("fifo_rd_en", fifo_rd_en, e_rd);
    chk1("rd_data_valid", rd_data_valid, m_pv);
    chk1("rd_data_first", rd_data_first, m_pf);
    chk1("rd_data_last", rd_data_last, m_pl);
    chk1("publish", publish, m_mode == 3);
    chk1("box_valid", box_valid, m_box);
    chk1("overflow", overflow, m_ovf);
    chk("phase", int'(phase), m_mode == 4 ? 3 : m_mode);
    chk("entry_cnt", int'(entry_cnt), m_wr);
    if (fifo_wr_en) t_wr++;
    if (fifo_rd_en) t_rd++;
    if (rd_data_valid && rd_data_first) t_first++;
    if (rd_data_valid && rd_data_last) begin t_last++; c_last = cyc; end
    if (publish) begin t_pub++; c_pub = cyc; p_entry = int'(entry_cnt); p_ovf = overflow; end
    if (phase == 2 && prev_phase != 2) c_red = cyc;
    prev_phase = int'(phase);
    if (rst) return;
    m_vs_d = lcd_vs;
    m_pv = e_rd;
    m_pf = e_rd && m_reads == 0;
    m_pl = e_rd && m_rem == 1;
    case (m_mode)
      0: if (vf && enable) begin m_mode = 1; m_age = 0; end
      1: begin
        if (e_srst) begin m_wr = 0; m_ovf = 0; end
        else if (e_wr) m_wr++;
        else if (fg) m_ovf = 1;
        m_age++;
        if (vf) begin m_mode = 2; m_rem = m_wr; m_reads = 0; end
      end
      2: if (vf || m_rem == 0) begin m_ovf |= m_rem != 0; m_mode = 3; end
         else if (e_rd) begin m_rem--; m_reads++; end
      3: begin m_box = m_wr != 0 && !m_ovf; m_hold = 0; m_mode = 4; end
      default: if (vf) begin
        if (m_hold == SKIP) begin m_mode = enable ? 1 : 0; m_age = 0; end
        else m_hold++;
      end
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_wr = t_wr; b_rd = t_rd; b_first = t_first; b_last = t_last; b_pub = t_pub;
  endtask

  task automatic frame(input int len, input int nfg, input bit px_fall, input bit px_srst);
    for (int c = 0; c < len; c++) begin
      lcd_vs    = c < 2;
      pix_valid = (c == 2 && px_fall) || (c == 3 && px_srst) || (c >= 5 && c < 5 + nfg);
      fg_pix    = pix_valid;
      tick();
    end
    pix_valid = 0;
    fg_pix    = 0;
  endtask

  task automatic rframe();
    int len, sp, rc;
    len    = 12 + int'($urandom % 30);
    sp     = int'($urandom % 4);
    rc     = ($urandom % 25 == 0) ? int'($urandom % 40) : -1;
    enable = ($urandom % 8) != 0;
    cap    = 2 + int'($urandom % 15);
    for (int c = 0; c < len; c++) begin
      lcd_vs    = c < 2;
      pix_valid = ($urandom % 2) == 0;
      fg_pix    = ($urandom % 3) == 0;
      stall     = int'($urandom % 8) < sp;
      rst       = c == rc;
      tick();
    end
    rst = 0;
  endtask

  initial begin
    rst = 1;
    tick();
    tick();
    chk("reset phase", int'(phase), 0);
    chk("reset entry_cnt", int'(entry_cnt), 0);
    chk1("reset box_valid", box_valid, 1'b0);
    chk1("reset overflow", overflow, 1'b0);
    rst = 0;
    enable = 1;
    snap();
    frame(30, 5, 0, 0);
    frame(30, 0, 0, 0);
    frame(30, 0, 0, 0);
    frame(30, 0, 0, 0);
    chk("normal writes", t_wr - b_wr, 5);
    chk("normal reads", t_rd - b_rd, 5);
    chk("normal first", t_first - b_first, 1);
    chk("normal last", t_last - b_last, 1);
    chk("normal publishes", t_pub - b_pub, 1);
    chk("normal entry at publish", p_entry, 5);
    chk("normal last to publish", c_pub - c_last, 1);
    chk1("normal overflow at publish", p_ovf, 1'b0);
    chk1("normal box_valid", box_valid, 1'b1);
    chk("normal recapture phase", int'(phase), 1);
    snap();
    frame(30, 0, 0, 0);
    chk("empty reads", t_rd - b_rd, 0);
    chk("empty publishes", t_pub - b_pub, 1);
    chk("empty reduce to publish", c_pub - c_red, 1);
    chk1("empty box_valid", box_valid, 1'b0);
    frame(30, 0, 0, 0);
    snap();
    frame(40, 10, 0, 0);
    frame(30, 0, 0, 0);
    chk("overflow writes", t_wr - b_wr, 8);
    chk("overflow reads", t_rd - b_rd, 8);
    chk("overflow last", t_last - b_last, 1);
    chk("overflow entry at publish", p_entry, 8);
    chk1("overflow flag at publish", p_ovf, 1'b1);
    chk1("overflow box_valid", box_valid, 1'b0);
    frame(30, 0, 0, 0);
    frame(30, 3, 0, 0);
    snap();
    stall = 1;
    frame(30, 0, 0, 0);
    frame(30, 0, 0, 0);
    stall = 0;
    chk("abort reads", t_rd - b_rd, 0);
    chk("abort last", t_last - b_last, 0);
    chk("abort publishes", t_pub - b_pub, 1);
    chk1("abort overflow at publish", p_ovf, 1'b1);
    chk1("abort overflow held", overflow, 1'b1);
    chk1("abort box_valid", box_valid, 1'b0);
    frame(30, 0, 0, 0);
    snap();
    frame(30, 2, 0, 1);
    chk("srst pixel entry_cnt", int'(entry_cnt), 2);
    chk1("srst pixel overflow", overflow, 1'b0);
    frame(30, 0, 1, 0);
    chk("boundary writes", t_wr - b_wr, 3);
    chk("boundary reads", t_rd - b_rd, 3);
    chk("boundary entry at publish", p_entry, 3);
    chk1("boundary box_valid", box_valid, 1'b1);
    frame(30, 0, 0, 0);
    frame(30, 4, 0, 0);
    enable = 0;
    snap();
    frame(30, 0, 0, 0);
    frame(30, 0, 0, 0);
    frame(30, 0, 0, 0);
    chk("enable drop publishes", t_pub - b_pub, 1);
    chk("enable drop idle phase", int'(phase), 0);
    enable = 1;
    frame(30, 6, 0, 0);
    frame(6, 0, 0, 0);
    #2;
    chk1("reading before reset", fifo_rd_en, 1'b1);
    rst = 1;
    #1;
    chk1("async rst rd_en", fifo_rd_en, 1'b0);
    chk1("async rst rd_valid", rd_data_valid, 1'b0);
    chk1("async rst wr_en", fifo_wr_en, 1'b0);
    chk1("async rst srst", fifo_srst, 1'b0);
    chk1("async rst publish", publish, 1'b0);
    chk1("async rst overflow", overflow, 1'b0);
    chk("async rst phase", int'(phase), 0);
    chk("async rst entry_cnt", int'(entry_cnt), 0);
    tick();
    rst = 0;
    repeat (150) rframe();
    stall = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
